// File: rtl/lsu_issue_queue.sv
// lsu_issue_queue: command FIFO in front of the load/store unit.
// It buffers {operation, DDR address, tag} commands and issues the head
// entry over the unit's valid/ready handshake. The head entry stays in the
// FIFO, and so stays stable on the outputs, until the unit reports
// completion. Only then is it popped and its tag reported.
module lsu_issue_queue #(
    parameter int Depth         = 4,
    parameter int TagWidth      = 4,
    parameter int TimeoutCycles = 1024,
    parameter int OpWidth       = 2,
    parameter int AddrWidth     = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [OpWidth-1:0]     cmd_op_i,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic [TagWidth-1:0]    cmd_tag_i,
    output logic [OpWidth-1:0]     lsu_operation_o,
    output logic [AddrWidth-1:0]   lsu_ddr_address_o,
    output logic                   lsu_valid_o,
    input  logic                   lsu_ready_i,
    output logic                   done_o,
    output logic [TagWidth-1:0]    done_tag_o,
    output logic                   busy_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   timeout_o
);

    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles);
    localparam logic [PtrWidth:0] FullLevel = (PtrWidth + 1)'(Depth);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [OpWidth-1:0]   opMem_q   [Depth];
    logic [AddrWidth-1:0] addrMem_q [Depth];
    logic [TagWidth-1:0]  tagMem_q  [Depth];

    logic [PtrWidth:0]   wrPtr_q, wrPtr_d;
    logic [PtrWidth:0]   rdPtr_q, rdPtr_d;
    logic [PtrWidth-1:0] wrIdx, rdIdx;
    logic [PtrWidth:0]   fill;
    logic                full, empty, push, pop, handshake;

    logic [CntWidth-1:0] busyCnt_q, busyCnt_d, busyCntInc;
    logic                done_q, done_d;
    logic [TagWidth-1:0] doneTag_q, doneTag_d;
    logic                timeout_q, timeout_d;

    // Pointers carry one extra wrap bit, so their difference is the fill level.
    assign wrIdx = wrPtr_q[PtrWidth-1:0];
    assign rdIdx = rdPtr_q[PtrWidth-1:0];
    assign fill  = wrPtr_q - rdPtr_q;
    assign full  = (fill == FullLevel);
    assign empty = (fill == '0);
    assign push  = cmd_valid_i && !full;

    assign cmd_ready_o       = !full;
    assign count_o           = fill;
    assign lsu_operation_o   = empty ? '0 : opMem_q[rdIdx];
    assign lsu_ddr_address_o = empty ? '0 : addrMem_q[rdIdx];
    assign done_o            = done_q;
    assign done_tag_o        = doneTag_q;
    assign timeout_o         = timeout_q;

    // State register of the issue FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on a handshake, return when the unit is ready again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = BUSY;
            BUSY:    if (lsu_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: offer the head only in IDLE, and pop it on completion in BUSY.
    always_comb begin
        lsu_valid_o = 1'b0;
        busy_o      = 1'b0;
        handshake   = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                lsu_valid_o = !empty;
                handshake   = !empty && lsu_ready_i;
            end
            BUSY: begin
                busy_o = 1'b1;
                pop    = lsu_ready_i;
            end
            default: ;
        endcase
    end

    // Storage array is written only; it needs no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            opMem_q[wrIdx]   <= cmd_op_i;
            addrMem_q[wrIdx] <= cmd_addr_i;
            tagMem_q[wrIdx]  <= cmd_tag_i;
        end
    end

    // Next values for the pointers, the busy watchdog and the completion report.
    always_comb begin
        wrPtr_d    = wrPtr_q + {{PtrWidth{1'b0}}, push};
        rdPtr_d    = rdPtr_q + {{PtrWidth{1'b0}}, pop};
        busyCntInc = (busyCnt_q == CntMax) ? busyCnt_q : busyCnt_q + 1'b1;
        busyCnt_d  = busyCnt_q;
        if (handshake) begin
            busyCnt_d = '0;
        end else if (busy_o) begin
            busyCnt_d = busyCntInc;
        end
        timeout_d = timeout_q || (busy_o && !lsu_ready_i && (busyCntInc == CntMax));
        done_d    = pop;
        doneTag_d = pop ? tagMem_q[rdIdx] : doneTag_q;
    end

    // Datapath registers; an asynchronous reset drops any in-flight command silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            busyCnt_q <= '0;
            done_q    <= 1'b0;
            doneTag_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            busyCnt_q <= busyCnt_d;
            done_q    <= done_d;
            doneTag_q <= doneTag_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// tb_lsu_issue_queue: bench for lsu_issue_queue. A transaction-level model
// (a queue of commands plus an in-flight flag) predicts every output each
// cycle, while a small load/store unit model answers the handshake with a
// configurable number of working beats.
module tb_lsu_issue_queue;

    localparam int Depth         = 4;
    localparam int TagWidth      = 4;
    localparam int TimeoutCycles = 16;
    localparam int OpWidth       = 2;
    localparam int AddrWidth     = 32;

    localparam logic [1:0] OpLdv  = 2'd0;
    localparam logic [1:0] OpSv   = 2'd1;
    localparam logic [1:0] OpLdtm = 2'd2;
    localparam logic [1:0] OpStm  = 2'd3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic [OpWidth-1:0]   cmd_op_i;
    logic [AddrWidth-1:0] cmd_addr_i;
    logic [TagWidth-1:0]  cmd_tag_i;
    logic [OpWidth-1:0]   lsu_operation_o;
    logic [AddrWidth-1:0] lsu_ddr_address_o;
    logic                 lsu_valid_o;
    logic                 lsu_ready_i;
    logic                 done_o;
    logic [TagWidth-1:0]  done_tag_o;
    logic                 busy_o;
    logic [2:0]           count_o;
    logic                 timeout_o;

    lsu_issue_queue #(
        .Depth(Depth),
        .TagWidth(TagWidth),
        .TimeoutCycles(TimeoutCycles),
        .OpWidth(OpWidth),
        .AddrWidth(AddrWidth)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i),
        .cmd_addr_i(cmd_addr_i),
        .cmd_tag_i(cmd_tag_i),
        .lsu_operation_o(lsu_operation_o),
        .lsu_ddr_address_o(lsu_ddr_address_o),
        .lsu_valid_o(lsu_valid_o),
        .lsu_ready_i(lsu_ready_i),
        .done_o(done_o),
        .done_tag_o(done_tag_o),
        .busy_o(busy_o),
        .count_o(count_o),
        .timeout_o(timeout_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [3:0]  tag;
    } cmd_t;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [3:0]  tag;
        int          expCount;
        logic        expCmdReady;
        logic        expLsuValid;
    } vec_t;

    cmd_t       refQ[$];
    bit         refBusy;
    bit         refDone;
    bit         refTimeout;
    logic [3:0] refDoneTag;
    int         refBusyCycles;

    int         lsuBeats;
    int         lsuLeft;
    bit         manualReady;
    logic       manualReadyVal;

    logic [3:0] doneLog[$];
    int         total;
    int         bad;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] addr,
                                 input logic [3:0] tag);
        cmd_valid_i = v;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_tag_i   = tag;
    endtask

    task automatic resetModel();
        refQ.delete();
        refBusy       = 1'b0;
        refDone       = 1'b0;
        refTimeout    = 1'b0;
        refDoneTag    = '0;
        refBusyCycles = 0;
        lsuLeft       = 0;
    endtask

    task automatic checkModel();
        logic [1:0]  expOp;
        logic [31:0] expAddr;
        expOp   = '0;
        expAddr = '0;
        if (refQ.size() > 0) begin
            expOp   = refQ[0].op;
            expAddr = refQ[0].addr;
        end
        checkOutput("cmd_ready", 64'(cmd_ready_o), 64'(refQ.size() < Depth));
        checkOutput("count", 64'(count_o), 64'(refQ.size()));
        checkOutput("busy", 64'(busy_o), 64'(refBusy));
        checkOutput("lsu_valid", 64'(lsu_valid_o), 64'(!refBusy && refQ.size() > 0));
        checkOutput("operation", 64'(lsu_operation_o), 64'(expOp));
        checkOutput("address", 64'(lsu_ddr_address_o), 64'(expAddr));
        checkOutput("done", 64'(done_o), 64'(refDone));
        if (refDone) checkOutput("done_tag", 64'(done_tag_o), 64'(refDoneTag));
        checkOutput("timeout", 64'(timeout_o), 64'(refTimeout));
    endtask

    task automatic checkReset();
        checkOutput("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        checkOutput("rst_count", 64'(count_o), 64'd0);
        checkOutput("rst_lsu_valid", 64'(lsu_valid_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_done_tag", 64'(done_tag_o), 64'd0);
        checkOutput("rst_timeout", 64'(timeout_o), 64'd0);
        checkOutput("rst_operation", 64'(lsu_operation_o), 64'd0);
        checkOutput("rst_address", 64'(lsu_ddr_address_o), 64'd0);
    endtask

    // One clock cycle: decide the events from the model, advance both models, check.
    task automatic tick();
        bit   doPush, doHs, doPop;
        cmd_t c;
        doPush = cmd_valid_i && (refQ.size() < Depth);
        doHs   = !refBusy && (refQ.size() > 0) && lsu_ready_i;
        doPop  = refBusy && lsu_ready_i;
        c.op   = cmd_op_i;
        c.addr = cmd_addr_i;
        c.tag  = cmd_tag_i;
        @(posedge clk_i);
        #1;
        if (rst_ni) begin
            refDone = 1'b0;
            if (doPop) begin
                refDone    = 1'b1;
                refDoneTag = refQ[0].tag;
                refQ.delete(0);
                refBusy    = 1'b0;
            end else if (refBusy) begin
                refBusyCycles++;
                if (refBusyCycles >= TimeoutCycles) refTimeout = 1'b1;
            end
            if (doHs) begin
                refBusy       = 1'b1;
                refBusyCycles = 0;
            end
            if (doPush) refQ.push_back(c);
            if (doHs) lsuLeft = lsuBeats;
            else if (lsuLeft > 0) lsuLeft--;
        end
        lsu_ready_i = manualReady ? manualReadyVal : (lsuLeft == 0);
        checkModel();
        if (refDone) doneLog.push_back(refDoneTag);
    endtask

    task automatic waitDones(input int n, input int maxCycles, input string name);
        int cyc;
        cyc = 0;
        while (doneLog.size() < n && cyc < maxCycles) begin
            tick();
            cyc++;
        end
        if (doneLog.size() < n) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: got %0d done pulses expected %0d within %0d cycles",
                     name, doneLog.size(), n, maxCycles);
        end
    endtask

    vec_t vecs[6];

    // Main sequence: reset, directed scenarios, table, random traffic, summary.
    initial begin
        int   cyc;
        int   busySeen;
        bit   seenTimeout;
        bit   accepted;

        total = 0;
        bad = 0;
        manualReady = 1'b0;
        manualReadyVal = 1'b0;
        lsuBeats = 4;
        applyStimulus(1'b0, '0, '0, '0);
        lsu_ready_i = 1'b1;
        resetModel();

        vecs[0] = '{1'b1, OpSv,   32'h200, 4'd0, 1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, OpLdtm, 32'h210, 4'd1, 2, 1'b1, 1'b1};
        vecs[2] = '{1'b1, OpStm,  32'h220, 4'd2, 3, 1'b1, 1'b1};
        vecs[3] = '{1'b1, OpSv,   32'h230, 4'd3, 4, 1'b0, 1'b1};
        vecs[4] = '{1'b1, OpLdv,  32'h240, 4'd4, 4, 1'b0, 1'b1};
        vecs[5] = '{1'b1, OpLdv,  32'h240, 4'd4, 4, 1'b0, 1'b1};

        #12;
        checkReset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single LDV with a 4-beat unit.
        $display("[TB] single LDV");
        lsuBeats = 4;
        doneLog.delete();
        applyStimulus(1'b1, OpLdv, 32'h100, 4'd3);
        checkOutput("t1_valid_before_enq", 64'(lsu_valid_o), 64'd0);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("t1_valid_after_enq", 64'(lsu_valid_o), 64'd1);
        checkOutput("t1_count_one", 64'(count_o), 64'd1);
        waitDones(1, 20, "t1_done_wait");
        if (doneLog.size() > 0) checkOutput("t1_done_tag", 64'(doneLog[0]), 64'd3);
        checkOutput("t1_count_zero", 64'(count_o), 64'd0);
        tick();

        // Fill the queue with the unit refusing handshakes.
        $display("[TB] fill table");
        manualReady = 1'b1;
        manualReadyVal = 1'b0;
        lsu_ready_i = 1'b0;
        doneLog.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].tag);
            tick();
            checkOutput("tbl_count", 64'(count_o), 64'(vecs[i].expCount));
            checkOutput("tbl_cmd_ready", 64'(cmd_ready_o), 64'(vecs[i].expCmdReady));
            checkOutput("tbl_lsu_valid", 64'(lsu_valid_o), 64'(vecs[i].expLsuValid));
            checkOutput("tbl_head_addr", 64'(lsu_ddr_address_o), 64'h200);
        end

        // Drain the full queue while command 4 is still being offered.
        $display("[TB] drain with refill");
        manualReady = 1'b0;
        lsuBeats = 2;
        lsuLeft = 0;
        lsu_ready_i = 1'b1;
        cyc = 0;
        while (doneLog.size() < 5 && cyc < 100) begin
            accepted = cmd_valid_i && (refQ.size() < Depth);
            tick();
            cyc++;
            if (doneLog.size() == 1 && done_o && cmd_valid_i)
                checkOutput("t3_ready_after_pop", 64'(cmd_ready_o), 64'd1);
            if (accepted) begin
                applyStimulus(1'b0, '0, '0, '0);
                checkOutput("t3_count_after_refill", 64'(count_o), 64'd4);
            end
        end
        if (doneLog.size() < 5) begin
            total++;
            bad++;
            $display("[TB] FAIL t3_drain: got %0d done pulses expected 5", doneLog.size());
        end
        for (int i = 0; i < 5 && i < doneLog.size(); i++)
            checkOutput("t3_done_order", 64'(doneLog[i]), 64'(i));
        tick();

        // Timeout: the unit works far longer than TimeoutCycles.
        $display("[TB] timeout");
        doneLog.delete();
        lsuBeats = 25;
        applyStimulus(1'b1, OpStm, 32'h300, 4'd5);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        cyc = 0;
        busySeen = 0;
        seenTimeout = 1'b0;
        while (doneLog.size() < 1 && cyc < 60) begin
            if (refBusy && !lsu_ready_i) busySeen++;
            tick();
            cyc++;
            if (timeout_o && !seenTimeout) begin
                seenTimeout = 1'b1;
                checkOutput("t4_timeout_cycle", 64'(busySeen), 64'(TimeoutCycles));
                checkOutput("t4_no_done_yet", 64'(doneLog.size()), 64'd0);
            end
        end
        checkOutput("t4_timeout_seen", 64'(seenTimeout), 64'd1);
        checkOutput("t4_done_count", 64'(doneLog.size()), 64'd1);
        if (doneLog.size() > 0) checkOutput("t4_done_tag", 64'(doneLog[0]), 64'd5);
        tick();
        checkOutput("t4_timeout_sticky", 64'(timeout_o), 64'd1);

        // Reset mid-transfer, asserted and released between clock edges.
        $display("[TB] reset mid-transfer");
        doneLog.delete();
        lsuBeats = 4;
        applyStimulus(1'b1, OpLdv, 32'h400, 4'd6);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        cyc = 0;
        while (!refBusy && cyc < 10) begin
            tick();
            cyc++;
        end
        checkOutput("t5_in_flight", 64'(busy_o), 64'd1);
        tick();
        #3;
        rst_ni = 1'b0;
        #1;
        checkReset();
        resetModel();
        lsu_ready_i = 1'b1;
        tick();
        tick();
        #3;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("t5_no_done", 64'(doneLog.size()), 64'd0);
        checkOutput("t5_cmd_ready", 64'(cmd_ready_o), 64'd1);

        // Pointer wrap: ten commands through the four-entry queue.
        $display("[TB] pointer wrap");
        doneLog.delete();
        lsuBeats = 2;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2'(i % 4), 32'(32'h1000 + i * 64), 4'(i % 16));
            cyc = 0;
            accepted = 1'b0;
            while (!accepted && cyc < 20) begin
                accepted = refQ.size() < Depth;
                tick();
                cyc++;
            end
            if (!accepted) begin
                total++;
                bad++;
                $display("[TB] FAIL t6_accept: command %0d not accepted within 20 cycles", i);
            end
        end
        applyStimulus(1'b0, '0, '0, '0);
        waitDones(10, 200, "t6_done_wait");
        for (int i = 0; i < 10 && i < doneLog.size(); i++)
            checkOutput("t6_done_tag", 64'(doneLog[i]), 64'(i % 16));

        // Random traffic against the reference model.
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            lsuBeats = $urandom_range(1, 4);
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                          4'($urandom_range(0, 15)));
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0);
        cyc = 0;
        while ((refQ.size() > 0 || refBusy) && cyc < 200) begin
            tick();
            cyc++;
        end
        checkOutput("t7_drained", 64'(count_o), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
